// File: rtl/tetris_pkg.sv
// Shared timing defaults and DAS state encoding for the tetris input front end.
package tetris_pkg;

  localparam int CLK_HZ        = 50000000;
  localparam int DEBOUNCE_MS   = 20;
  localparam int DAS_DELAY_MS  = 250;
  localparam int DAS_RATE_MS   = 50;
  localparam int CYCLES_PER_MS = CLK_HZ / 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } das_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One key channel: 2-flop synchronizer, stable-count debouncer and press one-shot.
// With INPUT_AUTO_REPEAT_EN defined, channels with REPEAT_ALLOW != 0 also get the DAS repeat FSM.
module debounce_channel
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DAS_DELAY       = 8,
  parameter int DAS_RATE        = 3,
  parameter int REPEAT_ALLOW    = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pulse
);

  localparam int               DB_CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_db;
  logic [DB_CW-1:0] r_db_cnt;
  logic             r_pulse;
  logic             w_pressed;
  logic             w_accept;
  logic             w_db_nxt;
  logic             w_press;
  logic             w_rep;

  // Stage p0/p1: metastability synchronizer, idles at released (1)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= i_key_n;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_pressed = ~r_sync_p1;
  assign w_accept  = (w_pressed != r_db) && (r_db_cnt == DB_LAST);
  assign w_db_nxt  = w_accept ? w_pressed : r_db;
  assign w_press   = w_accept & w_pressed;

  // Debouncer: any sample that agrees with the accepted level restarts the count
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_db     <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_db <= w_db_nxt;
      if ((w_pressed == r_db) || w_accept) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_CW'(1);
      end
    end
  end

`ifdef INPUT_AUTO_REPEAT_EN
  localparam int                DAS_MAX   = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
  localparam int                DAS_CW    = $clog2(DAS_MAX + 1);
  localparam logic [DAS_CW-1:0] DLY_LAST  = DAS_CW'(DAS_DELAY - 1);
  localparam logic [DAS_CW-1:0] RATE_LAST = DAS_CW'(DAS_RATE - 1);

  das_state_t        r_state;
  das_state_t        w_state_nxt;
  logic [DAS_CW-1:0] r_das_cnt;
  logic [DAS_CW-1:0] w_das_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_das_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_das_cnt <= w_das_cnt_nxt;
    end
  end

  // Release is judged on the next debounced level so the FSM leaves in the same edge
  always_comb begin
    w_state_nxt   = r_state;
    w_das_cnt_nxt = r_das_cnt;
    w_rep         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press && (REPEAT_ALLOW != 0)) begin
          w_state_nxt   = DELAY;
          w_das_cnt_nxt = '0;
        end
      end
      DELAY: begin
        if (!w_db_nxt) begin
          w_state_nxt   = IDLE;
          w_das_cnt_nxt = '0;
        end else if (r_das_cnt == DLY_LAST) begin
          w_rep         = 1'b1;
          w_state_nxt   = REPEAT;
          w_das_cnt_nxt = '0;
        end else begin
          w_das_cnt_nxt = r_das_cnt + DAS_CW'(1);
        end
      end
      REPEAT: begin
        if (!w_db_nxt) begin
          w_state_nxt   = IDLE;
          w_das_cnt_nxt = '0;
        end else if (r_das_cnt == RATE_LAST) begin
          w_rep         = 1'b1;
          w_das_cnt_nxt = '0;
        end else begin
          w_das_cnt_nxt = r_das_cnt + DAS_CW'(1);
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_das_cnt_nxt = '0;
      end
    endcase
  end
`else
  logic w_unused_cfg;

  assign w_rep        = 1'b0;
  assign w_unused_cfg = (DAS_DELAY != 0) ^ (DAS_RATE != 0) ^ (REPEAT_ALLOW != 0);
`endif

  // Stage p2: registered output pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_press | w_rep;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/input_conditioner.sv
// Front end for gamelogic: turns raw active-low buttons into one-cycle move/rotate pulses.
// Optional macro INPUT_AUTO_REPEAT_EN adds DAS auto-repeat on left and right.
module input_conditioner
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS,
  parameter int DAS_DELAY       = CYCLES_PER_MS * DAS_DELAY_MS,
  parameter int DAS_RATE        = CYCLES_PER_MS * DAS_RATE_MS
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic key_rot_n,
  output logic left_final,
  output logic right_final,
  output logic rot_final
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DAS_DELAY      (DAS_DELAY),
    .DAS_RATE       (DAS_RATE),
    .REPEAT_ALLOW   (1)
  ) u_left (
    .i_clk  (CLOCK_50),
    .i_rst_n(resetn),
    .i_key_n(key_left_n),
    .o_pulse(left_final)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DAS_DELAY      (DAS_DELAY),
    .DAS_RATE       (DAS_RATE),
    .REPEAT_ALLOW   (1)
  ) u_right (
    .i_clk  (CLOCK_50),
    .i_rst_n(resetn),
    .i_key_n(key_right_n),
    .o_pulse(right_final)
  );

  // Rotate never auto-repeats
  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DAS_DELAY      (DAS_DELAY),
    .DAS_RATE       (DAS_RATE),
    .REPEAT_ALLOW   (0)
  ) u_rot (
    .i_clk  (CLOCK_50),
    .i_rst_n(resetn),
    .i_key_n(key_rot_n),
    .o_pulse(rot_final)
  );

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, DAS_DELAY=8, DAS_RATE=3.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int DB   = 4;
  localparam int DLY  = 8;
  localparam int RATE = 3;

  logic CLOCK_50    = 1'b0;
  logic resetn      = 1'b0;
  logic key_left_n  = 1'b1;
  logic key_right_n = 1'b1;
  logic key_rot_n   = 1'b1;
  logic left_final;
  logic right_final;
  logic rot_final;

  int checks   = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .DAS_DELAY      (DLY),
    .DAS_RATE       (RATE)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .key_left_n (key_left_n),
    .key_right_n(key_right_n),
    .key_rot_n  (key_rot_n),
    .left_final (left_final),
    .right_final(right_final),
    .rot_final  (rot_final)
  );

  // Expected left/right pulse after edge i of a press that goes low before edge 0
  // and is released before edge rel.
  function automatic logic das_exp(input int i, input int rel);
    logic e;
    e = (i == DB + 1) && (rel >= DB);
`ifdef INPUT_AUTO_REPEAT_EN
    if ((i >= DB + 1 + DLY) && (((i - (DB + 1 + DLY)) % RATE) == 0) && (i < rel + DB + 1))
      e = 1'b1;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    resetn      = 1'b0;
    key_left_n  = 1'b1;
    key_right_n = 1'b1;
    key_rot_n   = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) resetn = 1'b1;
      tick();
      got = {left_final, right_final, rot_final};
      checks++;
      if (got !== 3'b000) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=000", i, got);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] got, exp;
    for (int i = 0; i < 32; i++) begin
      key_left_n = (i < 20) ? 1'b0 : 1'b1;
      tick();
      got = {left_final, right_final, rot_final};
      exp = {das_exp(i, 20), 2'b00};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clean_press edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] got, exp;
    for (int i = 0; i < 40; i++) begin
      if (i < 12) key_rot_n = i[1];
      else        key_rot_n = (i < 27) ? 1'b0 : 1'b1;
      tick();
      got = {left_final, right_final, rot_final};
      exp = {2'b00, (i == 12 + DB + 1)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bounce edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] got;
    for (int i = 0; i < 15; i++) begin
      key_right_n = (i < 3) ? 1'b0 : 1'b1;
      tick();
      got = {left_final, right_final, rot_final};
      checks++;
      if (got !== 3'b000) begin
        failures++;
        $display("FAIL glitch edge=%0d got=%b exp=000", i, got);
      end
    end
  endtask

  task automatic test_min_press();
    logic [2:0] got, exp;
    for (int i = 0; i < 16; i++) begin
      key_right_n = (i < 4) ? 1'b0 : 1'b1;
      tick();
      got = {left_final, right_final, rot_final};
      exp = {1'b0, das_exp(i, 4), 1'b0};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL min_press edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] got, exp;
    for (int i = 0; i < 16; i++) begin
      key_left_n = (i < 6) ? 1'b0 : 1'b1;
      key_rot_n  = (i < 6) ? 1'b0 : 1'b1;
      tick();
      got = {left_final, right_final, rot_final};
      exp = {das_exp(i, 6), 1'b0, (i == DB + 1)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL simultaneous edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [2:0] got, exp;
    for (int i = 0; i < 52; i++) begin
      key_right_n = (i < 40) ? 1'b0 : 1'b1;
      key_rot_n   = (i < 40) ? 1'b0 : 1'b1;
      tick();
      got = {left_final, right_final, rot_final};
      exp = {1'b0, das_exp(i, 40), (i == DB + 1)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL long_hold edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, exp;
    key_left_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      resetn = (i < 5) ? 1'b1 : 1'b0;
      tick();
      got = {left_final, right_final, rot_final};
      checks++;
      if (got !== 3'b000) begin
        failures++;
        $display("FAIL reset_mid_drop edge=%0d got=%b exp=000", i, got);
      end
    end
    resetn = 1'b1;
    for (int j = 0; j < 20; j++) begin
      key_left_n = (j < 9) ? 1'b0 : 1'b1;
      tick();
      got = {left_final, right_final, rot_final};
      exp = {das_exp(j, 9), 2'b00};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_mid_repress edge=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_min_press();
    test_simultaneous();
    test_long_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
